// File: rtl/ofifo_drain_ctrl_if.sv
// ============================================================================
// Module   : ofifo_drain_ctrl_if
// Brief    : Job, ofifo-read and psum-SRAM-write signals of the ofifo drain
//            sequencer, with controller (slave) and environment (master) views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ofifo_drain_ctrl_if #(
  parameter int COL    = 8,
  parameter int BW     = 16,
  parameter int ADDR_W = 11
);
  logic                  start;
  logic [ADDR_W-1:0]     base_addr;
  logic [ADDR_W-1:0]     num_rows;
  logic                  ofifo_valid;
  logic [COL*BW-1:0]     ofifo_out;
  logic                  ofifo_rd;
  logic                  sram_wen;
  logic [ADDR_W-1:0]     sram_addr;
  logic [COL*BW-1:0]     sram_din;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, base_addr, num_rows, ofifo_valid, ofifo_out,
    output ofifo_rd, sram_wen, sram_addr, sram_din, busy, done
  );

  modport master (
    output start, base_addr, num_rows, ofifo_valid, ofifo_out,
    input  ofifo_rd, sram_wen, sram_addr, sram_din, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/ofifo_drain_ctrl.sv
// ============================================================================
// Module   : ofifo_drain_ctrl
// Brief    : Drains completed psum rows from the ofifo into consecutive psum
//            SRAM addresses. Optional macro OFIFO_DRAIN_LRELU_EN applies a
//            per-lane leaky ReLU (slope 2^-ALPHA_SHIFT) to each stored row.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofifo_drain_ctrl #(
  parameter int COL         = 8,
  parameter int BW          = 16,
  parameter int ADDR_W      = 11,
  parameter int RD_LAT      = 1,
  parameter int ALPHA_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  ofifo_drain_ctrl_if.slave    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);

`ifdef OFIFO_DRAIN_LRELU_EN
  localparam bit c_lrelu = 1'b1;
`else
  localparam bit c_lrelu = 1'b0;
`endif

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_num;
  logic [ADDR_W-1:0]   r_issued;
  logic [ADDR_W-1:0]   r_returned;
  // One bit per in-flight read; doubles as the read-pacing window.
  logic [RD_LAT-1:0]   r_inflight;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [COL*BW-1:0]   r_din;

  logic                w_rd;
  logic                w_busy;
  logic                w_done;
  logic                w_capture;
  logic [COL*BW-1:0]   w_post;

  assign w_capture = r_inflight[RD_LAT-1];

  always_comb begin
    w_post = bus.ofifo_out;
    for (int l = 0; l < COL; l++) begin
      if (c_lrelu && bus.ofifo_out[l*BW + BW - 1]) begin
        w_post[l*BW +: BW] = $signed(bus.ofifo_out[l*BW +: BW]) >>> ALPHA_SHIFT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.num_rows == '0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_rd && ((r_issued + c_one) == r_num)) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_returned == r_num) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_done = (r_state == S_DONE);
    w_rd   = (r_state == S_DRAIN) && bus.ofifo_valid &&
             (r_issued < r_num) && (r_inflight == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base     <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_inflight <= '0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      r_inflight <= (r_inflight << 1) | RD_LAT'(w_rd);
      r_wen      <= w_capture;
      if (r_state == S_IDLE && bus.start) begin
        r_base     <= bus.base_addr;
        r_num      <= bus.num_rows;
        r_issued   <= '0;
        r_returned <= '0;
      end else begin
        if (w_rd) begin
          r_issued <= r_issued + c_one;
        end
        if (w_capture) begin
          r_returned <= r_returned + c_one;
        end
      end
      // Address wraps naturally modulo 2^ADDR_W.
      if (w_capture) begin
        r_addr <= r_base + r_returned;
        r_din  <= w_post;
      end
    end
  end

  assign bus.ofifo_rd  = w_rd;
  assign bus.sram_wen  = r_wen;
  assign bus.sram_addr = r_addr;
  assign bus.sram_din  = r_din;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

endmodule

`default_nettype wire

// File: tb/tb_ofifo_drain_ctrl.sv
// ============================================================================
// Module   : tb_ofifo_drain_ctrl
// Brief    : Directed, table-driven bench for ofifo_drain_ctrl (RD_LAT=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ofifo_drain_ctrl;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int AW  = 11;
  localparam int RL  = 1;
  localparam int AS  = 3;

  localparam logic [COL*BW-1:0] c_junk = {COL{16'hA5A5}};

  typedef struct {
    logic          start;
    logic          valid;
    logic [AW-1:0] base;
    logic [AW-1:0] num;
    logic          exp_rd;
    logic          exp_wen;
    logic [AW-1:0] exp_addr;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ofifo_drain_ctrl_if #(.COL(COL), .BW(BW), .ADDR_W(AW)) bus ();

  ofifo_drain_ctrl #(
    .COL(COL), .BW(BW), .ADDR_W(AW), .RD_LAT(RL), .ALPHA_SHIFT(AS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_rd;
  int n_wen;
  int pend_row;
  logic prev_rd;
  logic use_fixed;
  logic [COL*BW-1:0] fixed_row;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [COL*BW-1:0] row_pat(input int k);
    logic [COL*BW-1:0] r;
    for (int l = 0; l < COL; l++) r[l*BW +: BW] = 16'(k * 811 + l * 4099 + 5);
    return r;
  endfunction

  function automatic logic [COL*BW-1:0] model(input logic [COL*BW-1:0] row);
    logic [COL*BW-1:0] r;
    logic signed [BW-1:0] v;
    for (int l = 0; l < COL; l++) begin
      v = row[l*BW +: BW];
`ifdef OFIFO_DRAIN_LRELU_EN
      if (v < 0) v = v >>> AS;
`endif
      r[l*BW +: BW] = v;
    end
    return r;
  endfunction

  task automatic clear_counts();
    n_rd = 0; n_wen = 0; pend_row = 0; prev_rd = 1'b0;
  endtask

  // One cycle: drive inputs after negedge, sample 1 ns later, model ofifo data.
  task automatic step(input logic st, input logic vl, input logic [AW-1:0] ba,
                      input logic [AW-1:0] nr);
    @(negedge clk);
    bus.ofifo_out   = prev_rd ? (use_fixed ? fixed_row : row_pat(pend_row)) : c_junk;
    bus.start       = st;
    bus.ofifo_valid = vl;
    bus.base_addr   = ba;
    bus.num_rows    = nr;
    #1;
    if (bus.ofifo_rd === 1'b1) begin
      pend_row = n_rd; n_rd++; prev_rd = 1'b1;
    end else begin
      prev_rd = 1'b0;
    end
    if (bus.sram_wen === 1'b1) begin
      if (!use_fixed) chk($sformatf("din row%0d", n_wen), 128'(bus.sram_din), 128'(model(row_pat(n_wen))));
      n_wen++;
    end
  endtask

  function automatic vec_t mk(input logic st, input logic vl, input logic [AW-1:0] ba,
                              input logic [AW-1:0] nr, input logic rd, input logic wen,
                              input logic [AW-1:0] ad, input logic bz, input logic dn);
    vec_t v;
    v.start = st; v.valid = vl; v.base = ba; v.num = nr; v.exp_rd = rd; v.exp_wen = wen;
    v.exp_addr = ad; v.exp_busy = bz; v.exp_done = dn;
    return v;
  endfunction

  task automatic run_table(input string tag);
    clear_counts();
    foreach (tbl[i]) begin
      step(tbl[i].start, tbl[i].valid, tbl[i].base, tbl[i].num);
      chk($sformatf("%s[%0d].rd", tag, i), 128'(bus.ofifo_rd), 128'(tbl[i].exp_rd));
      chk($sformatf("%s[%0d].wen", tag, i), 128'(bus.sram_wen), 128'(tbl[i].exp_wen));
      if (tbl[i].exp_wen)
        chk($sformatf("%s[%0d].addr", tag, i), 128'(bus.sram_addr), 128'(tbl[i].exp_addr));
      chk($sformatf("%s[%0d].busy", tag, i), 128'(bus.busy), 128'(tbl[i].exp_busy));
      chk($sformatf("%s[%0d].done", tag, i), 128'(bus.done), 128'(tbl[i].exp_done));
    end
  endtask

  task automatic run_job(input string tag, input logic [AW-1:0] ba, input logic [AW-1:0] nr,
                         input int budget, output int done_cyc);
    int done_cnt;
    int w0;
    logic [AW-1:0] ea;
    clear_counts();
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 0; c < budget; c++) begin
      w0 = n_wen;
      step(c == 0, 1'b1, ba, nr);
      if (bus.sram_wen === 1'b1) begin
        ea = ba + AW'(w0);
        chk($sformatf("%s.addr%0d", tag, w0), 128'(bus.sram_addr), 128'(ea));
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    chk({tag, ".reads"}, 128'(n_rd), 128'(nr));
    chk({tag, ".writes"}, 128'(n_wen), 128'(nr));
    chk({tag, ".done_cnt"}, 128'(done_cnt), 128'd1);
  endtask

  initial begin
    int dc;
    int cnt;
    int idx;
    bit hit;
    reset = 1'b1;
    use_fixed = 1'b0;
    fixed_row = '0;
    bus.start = 1'b1; bus.ofifo_valid = 1'b1; bus.base_addr = '0; bus.num_rows = 11'd3;
    bus.ofifo_out = '0;
    clear_counts();

    // Reset held 3 cycles with start asserted.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst.rd", 128'(bus.ofifo_rd), 128'd0);
      chk("rst.wen", 128'(bus.sram_wen), 128'd0);
      chk("rst.addr", 128'(bus.sram_addr), 128'd0);
      chk("rst.din", 128'(bus.sram_din), 128'd0);
      chk("rst.busy", 128'(bus.busy), 128'd0);
      chk("rst.done", 128'(bus.done), 128'd0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b0;
    step(1'b0, 1'b1, '0, '0);

    // Basic drain, with an ignored start/base/num change in cycle 4.
    tbl.delete();
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      hit = (c == 3 || c == 5 || c == 7 || c == 9);
      tbl.push_back(mk(c == 0 || c == 4, 1'b1, (c == 4) ? 11'd100 : 11'd16,
                       (c == 4) ? 11'd9 : 11'd4,
                       (c == 1 || c == 3 || c == 5 || c == 7), hit, 11'(16 + idx),
                       (c >= 1 && c <= 10), (c == 10)));
      if (hit) idx++;
    end
    run_table("basic");

    // Stall: ofifo_valid low for cycles 5..9.
    tbl.delete();
    idx = 0;
    for (int c = 0; c < 17; c++) begin
      hit = (c == 3 || c == 5 || c == 12 || c == 14);
      tbl.push_back(mk(c == 0, !(c >= 5 && c <= 9), 11'd16, 11'd4,
                       (c == 1 || c == 3 || c == 10 || c == 12), hit, 11'(16 + idx),
                       (c >= 1 && c <= 15), (c == 15)));
      if (hit) idx++;
    end
    run_table("stall");

    run_job("zero", 11'd5, 11'd0, 4, dc);
    chk("zero.done_cyc", 128'(dc), 128'd1);

    run_job("wrap", 11'd2047, 11'd2, 10, dc);
    chk("wrap.done_cyc", 128'(dc), 128'd6);

    // Mid-job reset after two writes of a 6-row job.
    clear_counts();
    cnt = 0;
    while (n_wen < 2 && cnt < 20) begin
      step(cnt == 0, 1'b1, 11'd40, 11'd6);
      cnt++;
    end
    chk("mrst.reached_2_writes", 128'(n_wen), 128'd2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst.async_wen", 128'(bus.sram_wen), 128'd0);
    chk("mrst.async_busy", 128'(bus.busy), 128'd0);
    chk("mrst.async_addr", 128'(bus.sram_addr), 128'd0);
    chk("mrst.async_din", 128'(bus.sram_din), 128'd0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) begin
        @(negedge clk);
        reset = 1'b0;
      end
      step(1'b0, 1'b1, 11'd40, 11'd6);
      if (bus.sram_wen === 1'b1 || bus.done === 1'b1 || bus.busy === 1'b1) cnt++;
    end
    chk("mrst.quiet_cycles", 128'(cnt), 128'd0);
    run_job("after_rst", 11'd200, 11'd3, 12, dc);
    chk("after_rst.done_cyc", 128'(dc), 128'd8);

    // Leaky-ReLU lanes: -64, 40, -1.
    clear_counts();
    use_fixed = 1'b1;
    fixed_row = '0;
    fixed_row[0*BW +: BW] = 16'hFFC0;
    fixed_row[1*BW +: BW] = 16'h0028;
    fixed_row[2*BW +: BW] = 16'hFFFF;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step(c == 0, 1'b1, 11'd7, 11'd1);
      if (bus.sram_wen === 1'b1) begin
        cnt++;
`ifdef OFIFO_DRAIN_LRELU_EN
        chk("lrelu.lane0", 128'(bus.sram_din[0*BW +: BW]), 128'(16'hFFF8));
`else
        chk("lrelu.lane0", 128'(bus.sram_din[0*BW +: BW]), 128'(16'hFFC0));
`endif
        chk("lrelu.lane1", 128'(bus.sram_din[1*BW +: BW]), 128'(16'h0028));
        chk("lrelu.lane2", 128'(bus.sram_din[2*BW +: BW]), 128'(16'hFFFF));
      end
    end
    chk("lrelu.writes", 128'(cnt), 128'd1);
    use_fixed = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ofifo_drain_ctrl.md
# ofifo_drain_ctrl

Sequencer that drains completed partial-sum rows from the output FIFO (`ofifo`) into the psum SRAM. On `start`, it issues paced `rd` pulses to the ofifo while the ofifo reports all columns valid. It then writes each returned row to consecutive SRAM addresses from a programmed base, and pulses `done` after the last write. It sits between the MAC array's ofifo and the psum SRAM write port, under the top-level core controller.

## Interface
Parameters:
- `col`, 8: number of ofifo columns.
- `bw`, 16: psum width per column (signed).
- `addr_w`, 11: SRAM address width.
- `rd_lat`, 1: cycles from `ofifo_rd` high to valid data on `ofifo_out`; legal range 1..3.
- `alpha_shift`, 3: leaky-ReLU slope is 2^-alpha_shift.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: begin a drain job; sampled only in IDLE.
- `base_addr` in addr_w: first SRAM address; latched on accepted `start`.
- `num_rows` in addr_w: rows to drain; latched on accepted `start`.
- `ofifo_valid` in 1: ofifo `o_valid`, meaning every column holds at least one entry.
- `ofifo_out` in col*bw: ofifo data.
- `ofifo_rd` out 1: ofifo `rd`.
- `sram_wen` out 1: SRAM write enable, active-high, registered.
- `sram_addr` out addr_w: SRAM write address, registered.
- `sram_din` out col*bw: SRAM write data, registered.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at job end.

## Operation
- States:
  - IDLE: `busy`=0.
    - `start`=1 latches `base_addr` and `num_rows`, clears counters `issued` and `returned`, and goes to DRAIN.
    - If `num_rows`=0, goes straight to DONE instead.
  - DRAIN: `ofifo_rd`=1 in a cycle iff all of the following hold:
    - `ofifo_valid`=1;
    - `issued` < `num_rows`;
    - no `ofifo_rd` was asserted in the previous `rd_lat` cycles. This pacing guarantees `ofifo_valid` reflects the prior pop, so the block never over-reads.
    - Each read increments `issued`. Go to FLUSH when `issued` reaches `num_rows`.
  - FLUSH: no reads. Wait until `returned` = `num_rows`, then go to DONE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Return path:
  - A `rd_lat`-deep valid shift register tracks in-flight reads.
  - When its output is 1, `ofifo_out` is captured into `sram_din`, `sram_wen`=1 next cycle, `sram_addr` = base + `returned`, and `returned` increments.
- Address arithmetic is modulo 2^addr_w: base 2047 with 2 rows writes addresses 2047, then 0.
- `start` while `busy`=1 is ignored. `num_rows` and `base_addr` changes mid-job are ignored.
- `ofifo_valid` dropping mid-job stalls reads; the job resumes when it returns. There is no timeout.

## Timing
- Reset values: `ofifo_rd`=0, `sram_wen`=0, `sram_addr`=0, `sram_din`=0, `busy`=0, `done`=0. State is IDLE and all counters are 0.
- `start` sampled at cycle t leads to `busy`=1 at t+1. The earliest `ofifo_rd` is at t+1.
- `ofifo_rd` at cycle r leads to data captured at r+rd_lat, and `sram_wen`=1 with that row at r+rd_lat+1.
- Maximum throughput: one row every rd_lat+1 cycles.
- `done` is asserted the cycle after the last `sram_wen`. `busy` falls together with `done` falling.
- `num_rows`=0: `done` at t+1, `busy`=1 for that one cycle, no reads or writes.
- Reset asserted mid-job: outputs clear immediately (asynchronously). In-flight rows are discarded; no partial `done` is produced.

## Configuration
- `OFIFO_DRAIN_LRELU_EN` defined: each bw lane of the captured row passes through leaky ReLU before `sram_din`.
  - Negative values become value >>> alpha_shift (arithmetic shift, rounds toward −inf).
  - Non-negative values pass unchanged.
  - Latency is unchanged.
- Macro undefined: `sram_din` is a bit-exact copy of `ofifo_out`.

## Test plan
- Reset: hold `reset` for 3 cycles. All outputs 0. Assert `start` during reset: no `busy`.
- Basic drain:
  - Stimulus: `rd_lat`=1, base=16, `num_rows`=4, `ofifo_valid` held 1.
  - Required: `ofifo_rd` at cycles 1, 3, 5, 7; `sram_wen` at 3, 5, 7, 9 with addresses 16..19 and data matching the model; `done` at 10.
- Stall: drop `ofifo_valid` for 5 cycles after the 2nd read. No reads during the stall, all 4 rows still written in order, `done` delayed by 5 cycles.
- Edge cases:
  - `num_rows`=0: `done` one cycle after `start`, no reads or writes.
  - base=2047, `num_rows`=2: writes to 2047, then 0.
  - `start` pulsed mid-job: ignored.
- Mid-job reset: assert `reset` after 2 writes of a 6-row job. No further `sram_wen` and no `done`. A new job after reset completes normally.
- Feature on/off: lane values −64, 40, −1 with `alpha_shift`=3.
  - Macro on: −8, 40, −1.
  - Macro off: −64, 40, −1.
